// File: rtl/ifmap_row_packer.sv
// Pixel-stream packer for the PE IFMap buffer: tags row start/end and writes PAR_WRITE words at once.
// Optional IFMAP_PACKER_STALL_CNT_EN adds a saturating count of buffer-full stall cycles (stall_cnt).
module ifmap_row_packer #(
  parameter int DATA_WIDTH   = 16,
  parameter int IFMAP_WIDTH  = DATA_WIDTH + 2,
  parameter int PAR_WRITE    = 7,
  parameter int ROW_LEN_SIZE = 8,
  parameter int ROW_CNT_SIZE = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ROW_LEN_SIZE-1:0]          row_len,
  input  logic [ROW_CNT_SIZE-1:0]          num_rows,
  input  logic [DATA_WIDTH-1:0]            pix_in,
  input  logic                             pix_valid,
  output logic                             pix_ready,
  input  logic                             buf_full,
  output logic [IFMAP_WIDTH*PAR_WRITE-1:0] IFMap_out,
  output logic                             wen_IFMap_out,
  output logic                             busy,
  output logic                             done,
  output logic                             cfg_err
`ifdef IFMAP_PACKER_STALL_CNT_EN
  ,
  output logic [15:0]                      stall_cnt
`endif
);

  localparam int SLOT_W = (PAR_WRITE > 1) ? $clog2(PAR_WRITE) : 1;
  localparam logic [SLOT_W-1:0]       LAST_SLOT = SLOT_W'(PAR_WRITE - 1);
  localparam logic [ROW_LEN_SIZE-1:0] PAR_LEN   = ROW_LEN_SIZE'(PAR_WRITE);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                  state;
  logic [IFMAP_WIDTH-1:0]  slots [PAR_WRITE];
  logic [SLOT_W-1:0]       slot_cnt;
  logic [ROW_LEN_SIZE-1:0] col_cnt;
  logic [ROW_CNT_SIZE-1:0] row_cnt;
  logic [ROW_LEN_SIZE-1:0] row_len_q;
  logic [ROW_CNT_SIZE-1:0] num_rows_q;
  logic                    last_word;
  logic                    accept;
  logic                    sor;
  logic                    eor;
  logic                    bad_cfg;

  assign accept        = pix_valid && pix_ready;
  assign sor           = (col_cnt == '0);
  assign eor           = (col_cnt == row_len_q - 1'b1);
  assign bad_cfg       = (row_len == '0) || (num_rows == '0) || ((row_len % PAR_LEN) != '0);
  assign pix_ready     = (state == FILL);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign wen_IFMap_out = (state == WRITE) && !buf_full;

  // Slot 0 holds the first pixel of the word and lands in the MSBs.
  always_comb begin
    IFMap_out = '0;
    for (int i = 0; i < PAR_WRITE; i++) begin
      IFMap_out[(PAR_WRITE-1-i)*IFMAP_WIDTH +: IFMAP_WIDTH] = slots[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      slot_cnt   <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      row_len_q  <= '0;
      num_rows_q <= '0;
      last_word  <= 1'b0;
      cfg_err    <= 1'b0;
      for (int i = 0; i < PAR_WRITE; i++) begin
        slots[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (bad_cfg) begin
              cfg_err <= 1'b1;
            end else begin
              row_len_q  <= row_len;
              num_rows_q <= num_rows;
              cfg_err    <= 1'b0;
              slot_cnt   <= '0;
              col_cnt    <= '0;
              row_cnt    <= '0;
              last_word  <= 1'b0;
              state      <= FILL;
            end
          end
        end
        FILL: begin
          if (accept) begin
            slots[slot_cnt] <= {sor, eor, pix_in};
            if (eor) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + 1'b1;
              // Rows start at slot 0, so the final eor always closes the last word.
              if (row_cnt == num_rows_q - 1'b1) begin
                last_word <= 1'b1;
              end
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
            if (slot_cnt == LAST_SLOT) begin
              slot_cnt <= '0;
              state    <= WRITE;
            end else begin
              slot_cnt <= slot_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          if (!buf_full) begin
            state <= last_word ? DONE : FILL;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef IFMAP_PACKER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (state == IDLE) begin
      if (start && !bad_cfg) begin
        stall_cnt <= '0;
      end
    end else if (state == WRITE && buf_full && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifmap_row_packer.sv
// Self-checking bench for ifmap_row_packer: randomized frames checked against a frame-level tagging model.
module tb_ifmap_row_packer;

  localparam int DW = 16;
  localparam int IW = DW + 2;
  localparam int PW = 7;
  localparam int WW = IW * PW;
  localparam int FRAME_BOUND = 4000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    row_len = '0;
  logic [7:0]    num_rows = '0;
  logic [DW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          buf_full = 1'b0;
  logic          pix_ready;
  logic [WW-1:0] IFMap_out;
  logic          wen_IFMap_out;
  logic          busy;
  logic          done;
  logic          cfg_err;
`ifdef IFMAP_PACKER_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  ifmap_row_packer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .row_len       (row_len),
    .num_rows      (num_rows),
    .pix_in        (pix_in),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .buf_full      (buf_full),
    .IFMap_out     (IFMap_out),
    .wen_IFMap_out (wen_IFMap_out),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err)
`ifdef IFMAP_PACKER_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  logic [WW-1:0] rx_q[$];
  logic [WW-1:0] exp_q[$];
  logic [DW-1:0] stim_q[$];
  int done_cnt, done_cyc, last_wen_cyc, first_wen_cyc, ready_viol;
  bit frame_done;

  always @(posedge clk) cyc_cnt++;

  // Buffer-side observer: records every write and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (wen_IFMap_out) begin
        if (rx_q.size() == 0) first_wen_cyc = cyc_cnt;
        rx_q.push_back(IFMap_out);
        last_wen_cyc = cyc_cnt;
        if (pix_ready) ready_viol++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc_cnt;
        frame_done = 1'b1;
        if (pix_ready) ready_viol++;
      end
    end
  end

  // Reference: pixel k of the frame sits in column k%len; words are consecutive groups of PW.
  function automatic void build_expected(input int len, input int rows);
    logic [WW-1:0] word;
    int k, c;
    exp_q.delete();
    for (int w = 0; w < (len * rows) / PW; w++) begin
      word = '0;
      for (int s = 0; s < PW; s++) begin
        k = w * PW + s;
        c = k % len;
        word[(PW-1-s)*IW +: IW] = {(c == 0), (c == len - 1), stim_q[k]};
      end
      exp_q.push_back(word);
    end
  endfunction

  task automatic reset_monitor();
    rx_q.delete();
    done_cnt = 0;
    ready_viol = 0;
    frame_done = 1'b0;
    first_wen_cyc = -1;
    last_wen_cyc = -1;
    done_cyc = -1;
  endtask

  task automatic fill_stim(input int n, input bit ramp);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(ramp ? DW'(i + 1) : DW'($urandom));
  endtask

  task automatic pulse_start(input int len, input int rows);
    @(posedge clk); #1;
    start = 1'b1;
    row_len = 8'(len);
    num_rows = 8'(rows);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input int len, input int rows, input int valid_pct, input int stall_pct,
                           input bit do_start, output int acc_cyc);
    int idx = 0;
    int cyc = 0;
    int n = len * rows;
    reset_monitor();
    build_expected(len, rows);
    if (do_start) pulse_start(len, rows);
    acc_cyc = -1;
    while ((idx < n || !frame_done) && cyc < FRAME_BOUND) begin
      pix_valid = (idx < n) && ($urandom_range(99) < valid_pct);
      pix_in = pix_valid ? stim_q[idx] : DW'($urandom);
      buf_full = ($urandom_range(99) < stall_pct);
      @(negedge clk);
      if (pix_valid && pix_ready) begin
        idx++;
        if (idx == PW && acc_cyc < 0) acc_cyc = cyc_cnt;
      end
      @(posedge clk); #1;
      cyc++;
    end
    pix_valid = 1'b0;
    buf_full = 1'b0;
    checks++;
    if (cyc >= FRAME_BOUND) begin
      errors++;
      $display("[TB] FAIL frame_timeout: accepted %0d of %0d pixels, done_seen=%0d, required done within %0d cycles",
               idx, n, frame_done, FRAME_BOUND);
    end
  endtask

  task automatic test_reset();
    int acc;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({IFMap_out, wen_IFMap_out, pix_ready, busy, done, cfg_err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got out=%h wen=%b rdy=%b busy=%b done=%b err=%b, required all 0",
               IFMap_out, wen_IFMap_out, pix_ready, busy, done, cfg_err);
    end
`ifdef IFMAP_PACKER_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_stall_cnt: got %0d required 0", stall_cnt);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    reset_monitor();
    pulse_start(7, 1);
    repeat (3) begin
      pix_valid = 1'b1;
      pix_in = DW'($urandom);
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, pix_ready} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL mid_fill_state: got busy=%b rdy=%b required 1 1", busy, pix_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({IFMap_out, wen_IFMap_out, pix_ready, busy, done, cfg_err} !== '0) begin
      errors++;
      $display("[TB] FAIL mid_frame_reset: got out=%h wen=%b rdy=%b busy=%b done=%b, required all 0",
               IFMap_out, wen_IFMap_out, pix_ready, busy, done);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rx_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_discard: got writes=%0d busy=%b required 0 0", rx_q.size(), busy);
    end
    fill_stim(7, 1'b0);
    run_frame(7, 1, 100, 0, 1'b1, acc);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== exp_q[0]) begin
      errors++;
      $display("[TB] FAIL post_reset_frame: got %0d writes first=%h required 1 write %h",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_single_row();
    int acc;
    logic [WW-1:0] lit;
    stim_q = '{16'd1, 16'd2, 16'd3, 16'd3, 16'd4, 16'd5, 16'd6};
    lit = {2'b10, 16'd1, 2'b00, 16'd2, 2'b00, 16'd3, 2'b00, 16'd3, 2'b00, 16'd4, 2'b00, 16'd5, 2'b01, 16'd6};
    run_frame(7, 1, 100, 0, 1'b1, acc);
    checks++;
    if (rx_q.size() != 1) begin
      errors++;
      $display("[TB] FAIL single_row_writes: got %0d required 1", rx_q.size());
    end
    checks++;
    if (rx_q.size() > 0 && rx_q[0] !== lit) begin
      errors++;
      $display("[TB] FAIL single_row_word: got %h required %h", rx_q[0], lit);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_wen_cyc + 1) begin
      errors++;
      $display("[TB] FAIL single_row_done: got %0d pulses at cycle %0d, required 1 at cycle %0d",
               done_cnt, done_cyc, last_wen_cyc + 1);
    end
    checks++;
    if (first_wen_cyc != acc + 1) begin
      errors++;
      $display("[TB] FAIL write_latency: got write at cycle %0d required %0d", first_wen_cyc, acc + 1);
    end
  endtask

  task automatic test_two_rows();
    int acc;
    fill_stim(28, 1'b1);
    run_frame(14, 2, 100, 0, 1'b1, acc);
    checks++;
    if (rx_q.size() != 4) begin
      errors++;
      $display("[TB] FAIL two_rows_writes: got %0d required 4", rx_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL two_rows_word%0d: got %h required %h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_wen_cyc + 1) begin
      errors++;
      $display("[TB] FAIL two_rows_done: got %0d pulses at cycle %0d, required 1 at cycle %0d",
               done_cnt, done_cyc, last_wen_cyc + 1);
    end
  endtask

  task automatic test_stall();
    int idx = 0;
    fill_stim(7, 1'b0);
    build_expected(7, 1);
    reset_monitor();
    buf_full = 1'b1;
    pulse_start(7, 1);
    for (int t = 0; t < 50 && idx < 7; t++) begin
      pix_valid = 1'b1;
      pix_in = stim_q[idx];
      @(negedge clk);
      if (pix_ready) idx++;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    checks++;
    if (idx != 7) begin
      errors++;
      $display("[TB] FAIL stall_fill: got %0d pixels accepted required 7", idx);
    end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checks++;
      if ({wen_IFMap_out, pix_ready, busy} !== 3'b001 || IFMap_out !== exp_q[0]) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got wen=%b rdy=%b busy=%b out=%h required 0 0 1 %h",
                 s, wen_IFMap_out, pix_ready, busy, IFMap_out, exp_q[0]);
      end
      @(posedge clk); #1;
    end
    buf_full = 1'b0;
    @(negedge clk);
    checks++;
    if (wen_IFMap_out !== 1'b1 || IFMap_out !== exp_q[0]) begin
      errors++;
      $display("[TB] FAIL stall_release: got wen=%b out=%h required 1 %h", wen_IFMap_out, IFMap_out, exp_q[0]);
    end
`ifdef IFMAP_PACKER_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd5) begin
      errors++;
      $display("[TB] FAIL stall_cnt: got %0d required 5", stall_cnt);
    end
`endif
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || pix_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_done: got done=%b rdy=%b required 1 0", done, pix_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cfg_err();
    int acc;
    int bad_len[4]  = '{5, 0, 7, 8};
    int bad_rows[4] = '{1, 3, 0, 2};
    for (int i = 0; i < 4; i++) begin
      pulse_start(bad_len[i], bad_rows[i]);
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL cfg_err_len%0d_rows%0d: got err=%b busy=%b required 1 0",
                 bad_len[i], bad_rows[i], cfg_err, busy);
      end
    end
    pulse_start(7, 1);
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cfg_err_clear: got err=%b busy=%b required 0 1", cfg_err, busy);
    end
    pulse_start(5, 1);
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_while_busy: got err=%b busy=%b required 0 1", cfg_err, busy);
    end
    pulse_start(14, 2);
    fill_stim(7, 1'b0);
    run_frame(7, 1, 100, 0, 1'b0, acc);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== exp_q[0] || done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL busy_start_ignored: got %0d writes %0d dones first=%h required 1 1 %h",
               rx_q.size(), done_cnt, (rx_q.size() > 0) ? rx_q[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_random();
    int acc, len, rows;
    for (int f = 0; f < 6; f++) begin
      len = PW * $urandom_range(1, 5);
      rows = $urandom_range(1, 4);
      fill_stim(len * rows, 1'b0);
      run_frame(len, rows, 60, 30, 1'b1, acc);
      checks++;
      if (rx_q.size() != exp_q.size()) begin
        errors++;
        $display("[TB] FAIL random%0d_writes: got %0d required %0d", f, rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++;
          $display("[TB] FAIL random%0d_word%0d: got %h required %h", f, i, rx_q[i], exp_q[i]);
        end
      end
      checks++;
      if (done_cnt != 1 || ready_viol != 0) begin
        errors++;
        $display("[TB] FAIL random%0d_ctrl: got %0d dones %0d ready-while-write required 1 0",
                 f, done_cnt, ready_viol);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    for (int f = 0; f < 2; f++) begin
      fill_stim(14, 1'b0);
      run_frame(7, 2, 100, 0, 1'b1, acc);
      checks++;
      if (rx_q.size() != 2 || rx_q[0] !== exp_q[0] || rx_q[1] !== exp_q[1]) begin
        errors++;
        $display("[TB] FAIL b2b%0d_words: got %0d writes first=%h required 2 first=%h",
                 f, rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : '0, exp_q[0]);
      end
      checks++;
      if (first_wen_cyc != acc + 1 || done_cyc != last_wen_cyc + 1) begin
        errors++;
        $display("[TB] FAIL b2b%0d_timing: got write %0d done %0d required write %0d done %0d",
                 f, first_wen_cyc, done_cyc, acc + 1, last_wen_cyc + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_two_rows();
    test_stall();
    test_cfg_err();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation still running after 50000 cycles, required completion");
    $fatal(1, "[TB] global timeout");
  end

endmodule
